// File: rtl/itcm_loader.sv
// Boot loader: packs a little-endian byte stream into 64-bit ITCM writes, holds the core in reset until done.
// Optional feature macro: ITCM_LOADER_CHECKSUM_EN (32-bit wrap-around byte sum on load_sum).
module itcm_loader #(
    parameter int ITCM_SIZE = 16384,
    parameter int AW        = 11
) (
    input  logic          clk,
    input  logic          cpurst_n,
    input  logic          load_start,
    input  logic [14:0]   load_len,
    input  logic          s_valid,
    input  logic [7:0]    s_data,
    output logic          s_ready,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [31:0]   load_sum,
    output logic          core_rst,
    input  logic          if_cs,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          itcm_cs,
    output logic          itcm_we,
    output logic [7:0]    itcm_wem,
    output logic [AW-1:0] itcm_addr,
    output logic [63:0]   itcm_wdata
);

    localparam int RW = $clog2(ITCM_SIZE + 1);

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, FIN} state_t;

    state_t          state_q;
    logic [AW-1:0]   ptr_q;
    logic [2:0]      idx_q;
    logic [7:0]      wem_q;
    logic [63:0]     shadow_q;
    logic [RW-1:0]   rem_q;
    logic            s_ready_q;
    logic            busy_q;
    logic            done_q;
    logic            err_q;
    logic            core_rst_q;
    logic            ld_cs_q;
    logic            ld_we_q;
    logic [7:0]      ld_wem_q;
    logic [AW-1:0]   ld_addr_q;
    logic [63:0]     ld_wdata_q;

    logic [63:0]     shadow_d;
    logic [7:0]      wem_d;
    logic            too_long;
    logic [RW-1:0]   len_clamped;
    logic            accept;

    assign too_long    = 32'(load_len) > ITCM_SIZE;
    assign len_clamped = too_long ? RW'(ITCM_SIZE) : RW'(load_len);
    assign accept      = s_valid && s_ready_q;

    // Shadow word and mask as they will look once the current byte lands in lane idx_q.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            assign shadow_d[gi*8 +: 8] = (idx_q == 3'(gi)) ? s_data : shadow_q[gi*8 +: 8];
            assign wem_d[gi]           = wem_q[gi] | (idx_q == 3'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!cpurst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            idx_q      <= '0;
            wem_q      <= '0;
            shadow_q   <= '0;
            rem_q      <= '0;
            s_ready_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            core_rst_q <= 1'b1;
            ld_cs_q    <= 1'b0;
            ld_we_q    <= 1'b0;
            ld_wem_q   <= '0;
            ld_addr_q  <= '0;
            ld_wdata_q <= '0;
        end else begin
            ld_cs_q  <= 1'b0;
            ld_we_q  <= 1'b0;
            ld_wem_q <= '0;
            case (state_q)
                IDLE, FIN: begin
                    state_q <= IDLE;
                    // busy is low in both states, so a start is accepted here only.
                    if (load_start) begin
                        ptr_q <= '0;
                        idx_q <= '0;
                        wem_q <= '0;
                        rem_q <= len_clamped;
                        err_q <= too_long;
                        if (len_clamped == '0) begin
                            state_q    <= FIN;
                            done_q     <= 1'b1;
                            core_rst_q <= 1'b0;
                        end else begin
                            state_q    <= COLLECT;
                            busy_q     <= 1'b1;
                            s_ready_q  <= 1'b1;
                            done_q     <= 1'b0;
                            core_rst_q <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        shadow_q <= shadow_d;
                        wem_q    <= wem_d;
                        idx_q    <= idx_q + 3'd1;
                        rem_q    <= rem_q - RW'(1);
                        if (idx_q == 3'd7 || rem_q == RW'(1)) begin
                            state_q    <= WRITE;
                            s_ready_q  <= 1'b0;
                            ld_cs_q    <= 1'b1;
                            ld_we_q    <= 1'b1;
                            ld_wem_q   <= wem_d;
                            ld_addr_q  <= ptr_q;
                            ld_wdata_q <= shadow_d;
                        end
                    end
                end
                WRITE: begin
                    ptr_q <= ptr_q + AW'(1);
                    idx_q <= '0;
                    wem_q <= '0;
                    if (rem_q == '0) begin
                        state_q    <= FIN;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        core_rst_q <= 1'b0;
                    end else begin
                        state_q   <= COLLECT;
                        s_ready_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef ITCM_LOADER_CHECKSUM_EN
    logic [31:0] sum_q;

    always_ff @(posedge clk) begin
        if (!cpurst_n) begin
            sum_q <= '0;
        end else if ((state_q == IDLE || state_q == FIN) && load_start) begin
            sum_q <= '0;
        end else if (state_q == COLLECT && accept) begin
            sum_q <= sum_q + 32'(s_data);
        end
    end

    assign load_sum = sum_q;
`else
    assign load_sum = '0;
`endif

    assign s_ready  = s_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign core_rst = core_rst_q;

    // Fetch owns the port whenever no load is in flight.
    assign if_gnt     = !busy_q && if_cs;
    assign itcm_cs    = busy_q ? ld_cs_q   : if_cs;
    assign itcm_we    = busy_q ? ld_we_q   : 1'b0;
    assign itcm_wem   = busy_q ? ld_wem_q  : 8'h00;
    assign itcm_addr  = busy_q ? ld_addr_q : if_addr;
    assign itcm_wdata = ld_wdata_q;

endmodule

// File: tb/tb_itcm_loader.sv
// Bench for itcm_loader: random byte streams checked against a byte-level model of the expected ITCM writes.
module tb_itcm_loader;

    localparam int SIZE = 16384;
    localparam int AW   = 11;

    logic          clk = 1'b0;
    logic          cpurst_n = 1'b0;
    logic          load_start = 1'b0;
    logic [14:0]   load_len = '0;
    logic          s_valid = 1'b0;
    logic [7:0]    s_data = '0;
    logic          s_ready, busy, done, err, core_rst;
    logic [31:0]   load_sum;
    logic          if_cs = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt, itcm_cs, itcm_we;
    logic [7:0]    itcm_wem;
    logic [AW-1:0] itcm_addr;
    logic [63:0]   itcm_wdata;

    always #5 clk = ~clk;

    itcm_loader #(.ITCM_SIZE(SIZE), .AW(AW)) dut (
        .clk(clk), .cpurst_n(cpurst_n), .load_start(load_start), .load_len(load_len),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .busy(busy), .done(done),
        .err(err), .load_sum(load_sum), .core_rst(core_rst), .if_cs(if_cs), .if_addr(if_addr),
        .if_gnt(if_gnt), .itcm_cs(itcm_cs), .itcm_we(itcm_we), .itcm_wem(itcm_wem),
        .itcm_addr(itcm_addr), .itcm_wdata(itcm_wdata)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t_start  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] sbytes [0:SIZE-1];

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    wem;
        logic [63:0]   data;
    } wr_t;
    wr_t wlog[$];

    // Every ITCM write seen on the port, in order.
    always @(negedge clk) begin
        if (itcm_cs === 1'b1 && itcm_we === 1'b1)
            wlog.push_back('{itcm_addr, itcm_wem, itcm_wdata});
    end

    // ---------------- stimulus helpers and reference model ----------------
    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) sbytes[i] = 8'($urandom);
    endtask

    task automatic start_load(input int len);
        load_len   = 15'(len);
        load_start = 1'b1;
        t_start    = cyc;
        wlog.delete();
        @(negedge clk);
        load_start = 1'b0;
    endtask

    // Offers sbytes[0..n-1]; counts port-ownership violations and stalled offers.
    task automatic stream(input int n, input bit gaps, input int poke_at,
                          output int viol, output int stalls, output bit to);
        int i = 0;
        int k = 0;
        viol = 0; stalls = 0; to = 1'b0;
        while (i < n) begin
            if (busy === 1'b1 && if_gnt !== 1'b0) viol++;
            if (busy === 1'b1 && itcm_cs === 1'b1 && itcm_we !== 1'b1) viol++;
            if (busy !== 1'b1 && itcm_we !== 1'b0) viol++;
            load_start = (k == poke_at);
            if (k == poke_at) load_len = 15'd3;
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
            end else begin
                s_valid = 1'b1;
                s_data  = sbytes[i];
                if (s_ready === 1'b1) i++;
                else stalls++;
            end
            @(negedge clk);
            k++;
            if (k > 20 * n + 100) begin
                to = 1'b1;
                break;
            end
        end
        s_valid    = 1'b0;
        load_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int lat, output bit to);
        to = 1'b1; lat = 0;
        for (int k = 0; k < budget; k++) begin
            if (done === 1'b1) begin
                to  = 1'b0;
                lat = cyc - t_start;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Byte i of the stream belongs in word i/8, lane i%8; returns the number of wrong/missing/extra writes.
    function automatic int bad_words(input int L);
        int nw  = (L + 7) / 8;
        int bad = (wlog.size() > nw) ? wlog.size() - nw : nw - wlog.size();
        for (int k = 0; k < nw && k < wlog.size(); k++) begin
            logic [7:0]  ew;
            logic [63:0] ed, m;
            int nb;
            nb = (L - 8 * k >= 8) ? 8 : L - 8 * k;
            ew = '0; ed = '0; m = '0;
            for (int b = 0; b < nb; b++) begin
                ew[b]        = 1'b1;
                ed[8*b +: 8] = sbytes[8*k + b];
                m[8*b +: 8]  = 8'hFF;
            end
            if (wlog[k].addr !== AW'(k) || wlog[k].wem !== ew || (wlog[k].data & m) !== ed) bad++;
        end
        return bad;
    endfunction

    function automatic logic [31:0] exp_sum(input int L);
        logic [31:0] s = '0;
`ifdef ITCM_LOADER_CHECKSUM_EN
        for (int i = 0; i < L; i++) s = s + 32'(sbytes[i]);
`endif
        return s;
    endfunction

    function automatic int min_latency(input int L);
        return L + (L + 7) / 8 + 1;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        cpurst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        n_checks++; if (load_sum !== 32'h0) begin n_fail++; $display("FAIL reset_sum: got %h want 0", load_sum); end
        n_checks++; if (core_rst !== 1'b1) begin n_fail++; $display("FAIL reset_core_rst: got %b want 1", core_rst); end
        n_checks++; if ({itcm_cs, itcm_we, itcm_wem} !== 10'h0) begin n_fail++; $display("FAIL reset_itcm_ctl: got cs=%b we=%b wem=%h want 0", itcm_cs, itcm_we, itcm_wem); end
        n_checks++; if (itcm_addr !== '0 || itcm_wdata !== 64'h0) begin n_fail++; $display("FAIL reset_itcm_data: got addr=%h wdata=%h want 0", itcm_addr, itcm_wdata); end
        n_checks++; if (if_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_if_gnt: got %b want 0", if_gnt); end
        cpurst_n = 1'b1;
        @(negedge clk);
        $display("reset: released at cycle %0d", cyc);
    endtask

    task automatic test_full_word();
        int viol, stalls, lat;
        bit to1, to2;
        for (int i = 0; i < 16; i++) sbytes[i] = 8'(i);
        start_load(16);
        n_checks++; if ({busy, s_ready, done, core_rst} !== 4'b1101) begin n_fail++; $display("FAIL full_start: got busy/rdy/done/crst=%b want 1101", {busy, s_ready, done, core_rst}); end
        stream(16, 1'b0, -1, viol, stalls, to1);
        wait_done(50, lat, to2);
        n_checks++; if (to1 || to2) begin n_fail++; $display("FAIL full_timeout: got stream=%b done=%b want 0", to1, to2); end
        n_checks++; if (stalls !== 1) begin n_fail++; $display("FAIL full_stalls: got %0d want 1", stalls); end
        n_checks++; if (lat !== min_latency(16)) begin n_fail++; $display("FAIL full_latency: got %0d want %0d", lat, min_latency(16)); end
        n_checks++; if (bad_words(16) !== 0) begin n_fail++; $display("FAIL full_writes: got %0d bad of %0d want 0", bad_words(16), wlog.size()); end
        n_checks++; if (wlog.size() != 2 || wlog[0].wem !== 8'hFF || wlog[0].data !== 64'h0706050403020100 || wlog[1].data !== 64'h0F0E0D0C0B0A0908) begin
            n_fail++; $display("FAIL full_words: got n=%0d w0=%h w1=%h want 2 0706050403020100 0F0E0D0C0B0A0908", wlog.size(), (wlog.size() > 0) ? wlog[0].data : 64'h0, (wlog.size() > 1) ? wlog[1].data : 64'h0); end
        n_checks++; if ({busy, core_rst, err} !== 3'b000) begin n_fail++; $display("FAIL full_fin: got busy/crst/err=%b want 000", {busy, core_rst, err}); end
        n_checks++; if (load_sum !== exp_sum(16)) begin n_fail++; $display("FAIL full_sum: got %h want %h", load_sum, exp_sum(16)); end
        $display("load len=16 writes=%0d latency=%0d sum=%h", wlog.size(), lat, load_sum);
    endtask

    task automatic test_partial();
        int viol, stalls, lat;
        bit to1, to2;
        fill_random(11);
        start_load(11);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL partial_done_clear: got %b want 0", done); end
        stream(11, 1'b0, -1, viol, stalls, to1);
        wait_done(50, lat, to2);
        n_checks++; if (to1 || to2 || lat !== min_latency(11)) begin n_fail++; $display("FAIL partial_latency: got %0d want %0d", lat, min_latency(11)); end
        n_checks++; if (wlog.size() != 2 || wlog[1].addr !== AW'(1) || wlog[1].wem !== 8'h07) begin
            n_fail++; $display("FAIL partial_last: got n=%0d addr=%h wem=%h want 2 001 07", wlog.size(), (wlog.size() > 1) ? wlog[1].addr : AW'(0), (wlog.size() > 1) ? wlog[1].wem : 8'h0); end
        n_checks++; if (bad_words(11) !== 0) begin n_fail++; $display("FAIL partial_writes: got %0d bad want 0", bad_words(11)); end
        n_checks++; if (load_sum !== exp_sum(11)) begin n_fail++; $display("FAIL partial_sum: got %h want %h", load_sum, exp_sum(11)); end
        $display("load len=11 writes=%0d latency=%0d sum=%h", wlog.size(), lat, load_sum);
    endtask

    task automatic test_zero_len();
        bit saw_busy;
        start_load(0);
        saw_busy = (busy !== 1'b0);
        @(negedge clk);
        saw_busy = saw_busy || (busy !== 1'b0);
        n_checks++; if (saw_busy) begin n_fail++; $display("FAIL zero_busy: got 1 want 0"); end
        n_checks++; if (done !== 1'b1 || core_rst !== 1'b0) begin n_fail++; $display("FAIL zero_done: got done=%b crst=%b want 1 0", done, core_rst); end
        n_checks++; if (wlog.size() !== 0) begin n_fail++; $display("FAIL zero_writes: got %0d want 0", wlog.size()); end
        n_checks++; if (err !== 1'b0 || load_sum !== 32'h0) begin n_fail++; $display("FAIL zero_flags: got err=%b sum=%h want 0 0", err, load_sum); end
        $display("load len=0 writes=%0d done=%b", wlog.size(), done);
    endtask

    task automatic test_clamp();
        int viol, stalls, lat;
        bit to1, to2;
        fill_random(SIZE);
        start_load(20000);
        stream(SIZE, 1'b0, -1, viol, stalls, to1);
        wait_done(50, lat, to2);
        n_checks++; if (to1 || to2 || lat !== min_latency(SIZE)) begin n_fail++; $display("FAIL clamp_latency: got %0d want %0d", lat, min_latency(SIZE)); end
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL clamp_err: got %b want 1", err); end
        n_checks++; if (wlog.size() != 2048 || wlog[2047].addr !== AW'(11'h7FF)) begin
            n_fail++; $display("FAIL clamp_count: got n=%0d last=%h want 2048 7ff", wlog.size(), (wlog.size() > 0) ? wlog[wlog.size()-1].addr : AW'(0)); end
        n_checks++; if (bad_words(SIZE) !== 0) begin n_fail++; $display("FAIL clamp_writes: got %0d bad want 0", bad_words(SIZE)); end
        n_checks++; if (load_sum !== exp_sum(SIZE)) begin n_fail++; $display("FAIL clamp_sum: got %h want %h", load_sum, exp_sum(SIZE)); end
        $display("load len=20000 clamped writes=%0d err=%b latency=%0d", wlog.size(), err, lat);
        // err is sticky only until the next accepted start.
        fill_random(3);
        start_load(3);
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL clamp_err_clear: got %b want 0", err); end
        stream(3, 1'b0, -1, viol, stalls, to1);
        wait_done(50, lat, to2);
        n_checks++; if (to2 || bad_words(3) !== 0) begin n_fail++; $display("FAIL clamp_after: got %0d bad timeout=%b want 0 0", bad_words(3), to2); end
        $display("load len=3 writes=%0d latency=%0d", wlog.size(), lat);
    endtask

    task automatic test_arbitration();
        int viol, stalls, lat, len;
        bit to1, to2;
        logic [AW-1:0] a;
        len = $urandom_range(9, 40);
        fill_random(len);
        if_cs   = 1'b1;
        if_addr = AW'($urandom);
        start_load(len);
        stream(len, 1'b1, -1, viol, stalls, to1);
        wait_done(50, lat, to2);
        n_checks++; if (to1 || to2) begin n_fail++; $display("FAIL arb_timeout: got stream=%b done=%b want 0", to1, to2); end
        n_checks++; if (viol !== 0) begin n_fail++; $display("FAIL arb_ownership: got %0d violations want 0", viol); end
        n_checks++; if (bad_words(len) !== 0) begin n_fail++; $display("FAIL arb_writes: got %0d bad want 0", bad_words(len)); end
        a = AW'($urandom);
        if_addr = a;
        #1;
        n_checks++; if (if_gnt !== 1'b1 || itcm_cs !== 1'b1 || itcm_we !== 1'b0 || itcm_wem !== 8'h00) begin
            n_fail++; $display("FAIL arb_fetch_ctl: got gnt=%b cs=%b we=%b wem=%h want 1 1 0 00", if_gnt, itcm_cs, itcm_we, itcm_wem); end
        n_checks++; if (itcm_addr !== a) begin n_fail++; $display("FAIL arb_fetch_addr: got %h want %h", itcm_addr, a); end
        if_cs = 1'b0;
        #1;
        n_checks++; if (if_gnt !== 1'b0 || itcm_cs !== 1'b0) begin n_fail++; $display("FAIL arb_idle: got gnt=%b cs=%b want 0 0", if_gnt, itcm_cs); end
        @(negedge clk);
        $display("load len=%0d gapped with fetch pressure writes=%0d latency=%0d", len, wlog.size(), lat);
    endtask

    task automatic test_abort();
        int viol, stalls, lat;
        bit to1, to2;
        fill_random(8);
        start_load(8);
        stream(5, 1'b0, -1, viol, stalls, to1);
        cpurst_n = 1'b0;
        @(negedge clk);
        n_checks++; if ({busy, s_ready, done, core_rst} !== 4'b0001) begin n_fail++; $display("FAIL abort_state: got busy/rdy/done/crst=%b want 0001", {busy, s_ready, done, core_rst}); end
        n_checks++; if (wlog.size() !== 0) begin n_fail++; $display("FAIL abort_writes: got %0d want 0", wlog.size()); end
        cpurst_n = 1'b1;
        @(negedge clk);
        $display("abort after 5 of 8 bytes, writes=%0d", wlog.size());
        fill_random(8);
        start_load(8);
        stream(8, 1'b0, 3, viol, stalls, to1);
        wait_done(50, lat, to2);
        n_checks++; if (to1 || to2 || lat !== min_latency(8)) begin n_fail++; $display("FAIL abort_reload_latency: got %0d want %0d", lat, min_latency(8)); end
        n_checks++; if (bad_words(8) !== 0 || wlog.size() != 1) begin n_fail++; $display("FAIL abort_reload_writes: got %0d bad n=%0d want 0 1", bad_words(8), wlog.size()); end
        n_checks++; if (load_sum !== exp_sum(8)) begin n_fail++; $display("FAIL abort_reload_sum: got %h want %h", load_sum, exp_sum(8)); end
        $display("load len=8 with mid-load start pulse writes=%0d latency=%0d", wlog.size(), lat);
    endtask

    task automatic test_random();
        int viol, stalls, lat, len;
        bit to1, to2, gaps;
        for (int r = 0; r < 6; r++) begin
            len  = $urandom_range(1, 120);
            gaps = 1'($urandom);
            fill_random(len);
            start_load(len);
            stream(len, gaps, -1, viol, stalls, to1);
            wait_done(50, lat, to2);
            n_checks++; if (to1 || to2 || (!gaps && lat !== min_latency(len))) begin n_fail++; $display("FAIL rand_latency: got %0d want %0d (len %0d)", lat, min_latency(len), len); end
            n_checks++; if (bad_words(len) !== 0) begin n_fail++; $display("FAIL rand_writes: got %0d bad want 0 (len %0d)", bad_words(len), len); end
            n_checks++; if (load_sum !== exp_sum(len) || core_rst !== 1'b0 || err !== 1'b0) begin
                n_fail++; $display("FAIL rand_status: got sum=%h crst=%b err=%b want %h 0 0", load_sum, core_rst, err, exp_sum(len)); end
            $display("load len=%0d gaps=%0b writes=%0d latency=%0d", len, gaps, wlog.size(), lat);
        end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_partial();
        test_zero_len();
        test_clamp();
        test_arbitration();
        test_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
